// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
package arb_pkg;
  localparam int NUM_REQ = 4;

  typedef enum logic {IDLE, GRANT} arb_state_t;
  typedef logic [1:0] req_idx_t;

  function automatic logic [NUM_REQ-1:0] onehot(input req_idx_t idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Rotating priority pick: first set request scanning upward from ptr+1, modulo 4.
// Purely combinational; no state and no backpressure.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output req_idx_t           pick,
  output logic               valid
);

  req_idx_t idx;

  // Walk from the farthest slot back to the nearest so the nearest set bit wins.
  always_comb begin
    pick  = ptr;
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ptr + req_idx_t'(i);
      if (req[idx]) begin
        pick  = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter holding each grant for a whole transaction.
// Grant 1 cycle after request in IDLE; one idle turnaround cycle after every release.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = ($clog2(HOLD_MAX + 1) > 0) ? $clog2(HOLD_MAX + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output req_idx_t           sel,
  output logic               busy,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  arb_state_t         state_q, state_d;
  req_idx_t           ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_d;
  req_idx_t           sel_d;
  logic               busy_d, timeout_d;
  req_idx_t           pick;
  logic               pick_vld;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt;
    sel_d     = sel;
    busy_d    = busy;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_vld) begin
          state_d = GRANT;
          gnt_d   = onehot(pick);
          sel_d   = pick;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // DONE outranks the watchdog, so a simultaneous expiry is a clean release.
        if (done || !req[sel] || (HOLD_MAX != 0 && cnt_q == CNT_LAST)) begin
          state_d   = IDLE;
          ptr_d     = sel;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = !done && req[sel];
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      gnt     <= '0;
      sel     <= 2'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

endmodule
